// File: rtl/aud_pkg.sv
// Shared definitions for the I2S/left-justified DAC player.
package aud_pkg;

  typedef enum logic [1:0] {S_IDLE, S_SYNC, S_PLAY} aud_state_e;

  localparam int AUD_MODE_LJ  = 0;
  localparam int AUD_MODE_I2S = 1;

endpackage

// File: rtl/aud_i2s_player_if.sv
// PCM sample-pair handshake between the DSP (master) and the player (slave).
interface aud_i2s_player_if #(parameter int DATA_W = 16);
  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] left;
  logic [DATA_W-1:0] right;

  modport master (output valid, left, right, input ready);
  modport slave  (input valid, left, right, output ready);
endinterface

// File: rtl/aud_slot_shifter.sv
// Serializes one slot MSB-first; a load restarts the slot and truncates any unsent bits.
module aud_slot_shifter import aud_pkg::*; #(
  parameter int DATA_W    = 16,
  parameter int I2S_DELAY = 1
) (
  input  logic              i_bclk,
  input  logic              i_rst_n,
  input  logic              clr,
  input  logic              load,
  input  logic [DATA_W-1:0] sample,
  output logic              sdo
);
  localparam int             CW   = $clog2(DATA_W + 2);
  localparam bit             DLY  = (I2S_DELAY == AUD_MODE_I2S);
  // bit_cnt counts emitted slot bits, including the leading I2S zero
  localparam logic [CW-1:0]  LAST = CW'(DATA_W + int'(DLY));

  logic [DATA_W-1:0] sr;
  logic [CW-1:0]     bit_cnt;

  always_ff @(posedge i_bclk) begin
    if (!i_rst_n || (clr && !load)) begin
      sr      <= '0;
      bit_cnt <= '0;
      sdo     <= 1'b0;
    end else if (load) begin
      bit_cnt <= CW'(1);
      if (DLY) begin
        sdo <= 1'b0;
        sr  <= sample;
      end else begin
        sdo <= sample[DATA_W-1];
        sr  <= sample << 1;
      end
    end else if (bit_cnt < LAST) begin
      sdo     <= sr[DATA_W-1];
      sr      <= sr << 1;
      bit_cnt <= bit_cnt + 1'b1;
    end else begin
      sdo <= 1'b0;
    end
  end
endmodule

// File: rtl/aud_i2s_player.sv
// Stereo/mono PCM player: one-pair holding buffer, LRCK-aligned framing, underrun flag.
module aud_i2s_player import aud_pkg::*; #(
  parameter int DATA_W    = 16,
  parameter int I2S_DELAY = 1,
  parameter int STEREO    = 1
) (
  input  logic              i_bclk,
  input  logic              i_rst_n,
  input  logic              i_en,
  input  logic              i_daclrck,
  aud_i2s_player_if.slave   pcm,
  output logic              o_aud_dacdat,
  output logic              o_underrun,
  output logic              o_busy
);
  aud_state_e        state;
  logic              lrck_q;
  logic              hold_full;
  logic [DATA_W-1:0] hold_l, hold_r, ch_r;
  logic              lr_edge, fs, xfer, slot_load;
  logic [DATA_W-1:0] sample;

  assign lr_edge   = i_daclrck != lrck_q;
  assign fs        = lr_edge && !i_daclrck;
  assign pcm.ready = !hold_full && (state != S_IDLE);
  assign xfer      = pcm.valid && pcm.ready;
  assign o_busy    = state != S_IDLE;
  // SYNC only reacts to a falling LRCK edge so playback never starts mid-frame
  assign slot_load = i_en && ((state == S_PLAY && lr_edge) || (state == S_SYNC && fs));
  // left slot bypasses a channel register: it is fed straight from the buffer
  assign sample    = fs ? (hold_full ? hold_l : '0) : ch_r;

  always_ff @(posedge i_bclk) begin
    if (!i_rst_n) begin
      state      <= S_IDLE;
      lrck_q     <= 1'b0;
      hold_full  <= 1'b0;
      hold_l     <= '0;
      hold_r     <= '0;
      ch_r       <= '0;
      o_underrun <= 1'b0;
    end else begin
      lrck_q     <= i_daclrck;
      o_underrun <= slot_load && fs && !hold_full;
      if (!i_en) begin
        state     <= S_IDLE;
        hold_full <= 1'b0;
      end else begin
        case (state)
          S_IDLE:  state <= S_SYNC;
          S_SYNC:  if (fs) state <= S_PLAY;
          default: ;
        endcase
        if (slot_load && fs) begin
          ch_r      <= hold_full ? hold_r : '0;
          hold_full <= 1'b0;
        end
        // a pair arriving on an underrun frame start is kept for the next frame
        if (xfer) begin
          hold_full <= 1'b1;
          hold_l    <= pcm.left;
          hold_r    <= (STEREO != 0) ? pcm.right : pcm.left;
        end
      end
    end
  end

  aud_slot_shifter #(.DATA_W(DATA_W), .I2S_DELAY(I2S_DELAY)) u_shift (
    .i_bclk  (i_bclk),
    .i_rst_n (i_rst_n),
    .clr     (!i_en || state != S_PLAY),
    .load    (slot_load),
    .sample  (sample),
    .sdo     (o_aud_dacdat)
  );
endmodule
